// File: rtl/sdram_arbiter.sv
// sdram_arbiter: hands the SDRAM pins to the init, write or refresh
// sub-controller through a one-hot select. It also owns the periodic
// refresh timer, and refresh takes priority over write requests.
// Optional watchdog: define SDRAM_ARB_WATCHDOG_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_INIT    | init sub-controller owns the pins, waiting for init_done
// ST_IDLE    | parked on the refresh path with ref_en low, arbitrating
// ST_WRITE   | write sub-controller owns the pins, waiting for wr_done
// ST_REFRESH | refresh sub-controller owns the pins, waiting for ref_done
module sdram_arbiter #(
  parameter int REF_PERIOD  = 750,
  parameter int REF_CNT_W   = 10,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic       wr_req,
  input  logic       wr_done,
  input  logic       ref_done,
  output logic [2:0] sel,
  output logic       init_en,
  output logic       wr_en,
  output logic       ref_en,
  output logic       wr_ack,
  output logic       ready,
  output logic       busy,
  output logic       ref_overrun,
  output logic       wdog_err
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_REFRESH} state_t;

  localparam logic [REF_CNT_W-1:0] REF_RELOAD = REF_CNT_W'(REF_PERIOD - 1);

  state_t               state, state_nxt;
  logic [REF_CNT_W-1:0] ref_cnt;
  logic                 ref_pending;
  logic                 tick;
  logic                 ref_finish;
  logic                 wdog_exp;
  logic                 ack_nxt;
  logic [2:0]           sel_nxt;

  // A tick is visible to the FSM in the same cycle, so a tick colliding
  // with wr_req in IDLE still wins arbitration.
  assign tick       = ready && (ref_cnt == '0);
  assign ref_finish = (state == ST_REFRESH) && ref_done;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              done_match;

  assign done_match = ((state == ST_INIT)    && init_done) ||
                      ((state == ST_WRITE)   && wr_done)   ||
                      ((state == ST_REFRESH) && ref_done);
  assign wdog_exp   = (state != ST_IDLE) && !done_match &&
                      (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Cycles spent waiting on a sub-controller; restarts on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (wdog_exp || (state_nxt != state)) wdog_cnt <= '0;
      else if (state != ST_IDLE)            wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_exp) wdog_err <= 1'b1;
    end
  end
`else
  // WDOG_CYCLES only matters with the watchdog built in; this folds to 0.
  assign wdog_exp = (WDOG_CYCLES < 0);
  assign wdog_err = 1'b0;
`endif

  // Next state, write acknowledge, and select for the state being entered.
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    case (state)
      ST_INIT:    if (init_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending || tick) state_nxt = ST_REFRESH;
        else if (wr_req)         state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_done) begin
          state_nxt = ST_IDLE;
          ack_nxt   = 1'b1;
        end
      end
      ST_REFRESH: if (ref_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_INIT;
    endcase
    if (wdog_exp) begin
      state_nxt = (state == ST_INIT) ? ST_INIT : ST_IDLE;
      ack_nxt   = 1'b0;
    end
    case (state_nxt)
      ST_INIT:  sel_nxt = 3'b001;
      ST_WRITE: sel_nxt = 3'b010;
      default:  sel_nxt = 3'b100;
    endcase
  end

  // State register with outputs registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      sel     <= 3'b001;
      init_en <= 1'b1;
      wr_en   <= 1'b0;
      ref_en  <= 1'b0;
      wr_ack  <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      init_en <= (state_nxt == ST_INIT);
      wr_en   <= (state_nxt == ST_WRITE);
      ref_en  <= (state_nxt == ST_REFRESH);
      wr_ack  <= ack_nxt;
      busy    <= (state_nxt != ST_IDLE);
      if ((state == ST_INIT) && init_done) ready <= 1'b1;
    end
  end

  // Refresh down-counter, pending flag and overrun detection. A tick in the
  // same cycle as ref_done is not an overrun: the old refresh is completing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt     <= REF_RELOAD;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if ((state == ST_INIT) && init_done) ref_cnt <= REF_RELOAD;
      else if (tick)                       ref_cnt <= REF_RELOAD;
      else if (ready)                      ref_cnt <= ref_cnt - 1'b1;
      if (tick)            ref_pending <= 1'b1;
      else if (ref_finish) ref_pending <= 1'b0;
      if (tick && ref_pending && !ref_finish) ref_overrun <= 1'b1;
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sequencer placed directly upstream of the SDRAM bus mux.
- Generates the one-hot 3-bit `sel` that gives the SDRAM pins to exactly one of three sub-controllers: init, write or refresh.
- Level enables start each sub-controller; a one-cycle done pulse returns control.
- Owns the periodic refresh timer. Arbitrates refresh against external write requests, with refresh having priority.

Parameters:
- REF_PERIOD, 750, clk cycles between refresh requests (15 us at 50 MHz).
- REF_CNT_W, 10, refresh counter width; must satisfy 2^REF_CNT_W > REF_PERIOD.
- WDOG_CYCLES, 4096, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  in  1  one-cycle pulse from the init sub-controller.
- wr_req  in  1  level write request; held until wr_ack.
- wr_done  in  1  one-cycle pulse from the write sub-controller.
- ref_done  in  1  one-cycle pulse from the refresh sub-controller.
- sel  out  3  one-hot mux select: 001 init, 010 write, 100 refresh.
- init_en  out  1  level enable to the init sub-controller.
- wr_en  out  1  level enable to the write sub-controller.
- ref_en  out  1  level enable to the refresh sub-controller.
- wr_ack  out  1  one-cycle grant-complete pulse to the requester.
- ready  out  1  high once initialisation has completed.
- busy  out  1  high when state is not IDLE.
- ref_overrun  out  1  sticky error flag.
- wdog_err  out  1  sticky error flag; tied 0 without the optional feature.

Behaviour:
- Reset values:
  - state=INIT, sel=001, init_en=1.
  - wr_en=0, ref_en=0, wr_ack=0, ready=0, busy=1.
  - ref_overrun=0, wdog_err=0, refresh counter=REF_PERIOD-1, ref_pending=0.
  - Reset is asynchronous. Asserting it mid-operation forces these values immediately.
- Output registration and sel legality:
  - All outputs are registered. sel and the enables change on the same edge as the state.
  - sel is never 000 and never multi-hot. The downstream mux decodes 000 as CS/RAS/CAS/WE all low, which is a LOAD MODE command.
- States:
  - INIT:
    - sel=001, init_en=1.
    - On init_done: go to IDLE, set ready=1 (sticky until reset), load the counter to REF_PERIOD-1 and start it.
  - IDLE:
    - Park with sel=100 and ref_en=0. The refresh sub-controller drives NOP when it is disabled.
    - If ref_pending, go to REFRESH.
    - Else if wr_req, go to WRITE.
    - Else stay in IDLE.
  - WRITE:
    - sel=010, wr_en=1.
    - On wr_done: go to IDLE, and assert wr_ack for exactly the next cycle.
  - REFRESH:
    - sel=100, ref_en=1.
    - On ref_done: clear ref_pending and go to IDLE.
- Latencies:
  - wr_req sampled high in IDLE with no pending refresh gives sel=010 and wr_en=1 on the next edge.
  - A request arriving during WRITE or REFRESH is evaluated after one IDLE cycle.
- Refresh timer:
  - Counts down once ready=1. At 0 it issues a tick, sets ref_pending and reloads REF_PERIOD-1.
  - Runs continuously in every state.
- Simultaneous events:
  - Tick and wr_req in the same IDLE cycle: refresh is granted first. WRITE follows after ref_done plus one IDLE cycle.
  - Tick in the same cycle as ref_done: the tick wins, so ref_pending stays 1 and another REFRESH follows.
  - Tick while ref_pending is already 1: ref_overrun=1, sticky until reset.
- Ignored inputs:
  - Done pulses arriving outside their matching state.
  - init_done after ready=1.
- Requester obligation: wr_req must drop the cycle after wr_ack. If it is still high in IDLE, it is treated as a new request.
- Busy: busy = (state != IDLE).

Optional Feature:
- Macro: SDRAM_ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on every state entry and increments while in INIT, WRITE or REFRESH.
  - Reaching WDOG_CYCLES without the matching done sets wdog_err=1 (sticky until reset) and forces the state to IDLE.
  - No wr_ack is issued on a watchdog exit. ref_pending is left unchanged.
  - A watchdog expiry in INIT returns to INIT and restarts the counter instead of going to IDLE, so ready stays 0.
- Without the macro: no watchdog counter; wdog_err is tied to 0.

Test Plan:
- Reset check (REF_PERIOD=8): release rst, pulse init_done at cycle 20 -> cycles 0-20: sel=001, init_en=1, ready=0; cycle 21: sel=100, init_en=0, ready=1, busy=0.
- Write grant: wr_req held high from IDLE -> next edge sel=010, wr_en=1, busy=1; pulse wr_done 5 cycles later -> next cycle wr_ack=1 for exactly one cycle, sel=100, wr_en=0.
- Periodic refresh: no writes -> ref_en rises 8 cycles after init_done and stays high until ref_done; the tick interval stays 8 cycles whatever the refresh duration.
- Tick collision: assert wr_req in the cycle ref_pending is set -> REFRESH (sel=100, ref_en=1) first; WRITE (sel=010) starts 2 cycles after ref_done; wr_ack after wr_done.
- Overrun: hold WRITE without wr_done across 2 REF_PERIODs -> ref_overrun=1 at the second tick and remains 1 after returning to IDLE.
- Async reset: assert rst mid-WRITE between clock edges -> sel=001, init_en=1, wr_en=0, ready=0 immediately, without waiting for a clock edge.
